// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for the core pipeline control
//
// Purpose: common definitions used by the hazard sequencer and its helpers.
//   md_state_t          mul/div sequencer state (IDLE, MD_RUN)
//   REG_X0              architectural zero register index
//   MD_TIMEOUT_DEFAULT  default cycle limit for a mul/div operation
package core_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        MD_RUN = 1'b1
    } md_state_t;

    localparam logic [4:0] REG_X0             = 5'd0;
    localparam int         MD_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard compare
//
// Purpose: flags when the instruction in ID reads the destination of a load in EX.
// Ports:
//   rs1_id, rs2_id      in   source registers of the ID instruction
//   use_rs1, use_rs2    in   ID instruction actually reads rs1 / rs2
//   ex_rd               in   destination register of the EX instruction
//   ex_wb_n             in   active-low: EX instruction writes a register
//   ex_memread          in   EX instruction is a load
//   lu                  out  load-use hazard present
module load_use_detect
    import core_pkg::*;
(
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic       use_rs1,
    input  logic       use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_wb_n,
    input  logic       ex_memread,
    output logic       lu
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = use_rs1 && (rs1_id == ex_rd);
    assign rs2_hit = use_rs2 && (rs2_id == ex_rd);

    // x0 is never a real dependency: its reads are always zero.
    assign lu = ex_memread && !ex_wb_n && (ex_rd != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage core
//
// Purpose: resolves hazards that forwarding cannot: load-use stalls, multi-cycle
// mul/div freezes with timeout, and redirect flushes for taken branches and traps.
// Ports:
//   clk_i, reset_i                  clock, asynchronous active-high reset
//   rs1_ID, rs2_ID, use_rs1_ID,     ID-stage source operands
//   use_rs2_ID
//   idex_rd, idex_wb, idex_memread  EX-stage destination info (idex_wb active-low)
//   ex_muldiv, md_done_i            mul/div request in EX and completion
//   branch_taken_EX, trap_i         redirect sources
//   stall_IF/ID/EX                  hold PC / IF/ID / ID/EX
//   bubble_EX, bubble_MEM           load NOP into ID/EX / EX/MEM
//   flush_IFID/IDEX/EXMEM           clear pipeline registers
//   md_start_o, md_abort_o          one-cycle pulses to the mul/div unit
//   md_busy_o                       mul/div operation in progress
//   md_timeout_o                    sticky timeout flag, cleared by reset only
module pipeline_hazard_ctrl
    import core_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEFAULT
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [4:0] rs1_ID,
    input  logic [4:0] rs2_ID,
    input  logic       use_rs1_ID,
    input  logic       use_rs2_ID,
    input  logic [4:0] idex_rd,
    input  logic       idex_wb,
    input  logic       idex_memread,
    input  logic       ex_muldiv,
    input  logic       md_done_i,
    input  logic       branch_taken_EX,
    input  logic       trap_i,
    output logic       stall_IF,
    output logic       stall_ID,
    output logic       stall_EX,
    output logic       bubble_EX,
    output logic       bubble_MEM,
    output logic       flush_IFID,
    output logic       flush_IDEX,
    output logic       flush_EXMEM,
    output logic       md_start_o,
    output logic       md_abort_o,
    output logic       md_busy_o,
    output logic       md_timeout_o
);

    localparam int CNT_W = $clog2(MD_TIMEOUT + 1);

    md_state_t        state;
    md_state_t        state_nxt;
    logic [CNT_W-1:0] md_cnt;
    logic [CNT_W-1:0] md_cnt_nxt;
    logic             md_timeout_q;
    logic             md_timeout_set;

    logic kill;
    logic lu;
    logic md_at_limit;
    logic md_go;
    logic md_hold;
    logic md_tmo;

    load_use_detect u_load_use_detect (
        .rs1_id     (rs1_ID),
        .rs2_id     (rs2_ID),
        .use_rs1    (use_rs1_ID),
        .use_rs2    (use_rs2_ID),
        .ex_rd      (idex_rd),
        .ex_wb_n    (idex_wb),
        .ex_memread (idex_memread),
        .lu         (lu)
    );

    assign kill        = trap_i;
    assign md_at_limit = (md_cnt == CNT_W'(MD_TIMEOUT));

    // Start only from IDLE and only if the mul/div in EX is not being discarded.
    assign md_go   = (state == IDLE) && ex_muldiv && !kill && !branch_taken_EX;
    assign md_hold = (state == MD_RUN) && !kill && !md_done_i && !md_at_limit;
    // A timeout releases the pipeline as if done, but aborts the unit.
    assign md_tmo  = (state == MD_RUN) && !kill && !md_done_i && md_at_limit;

    // State register, cycle counter and sticky timeout flag.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state        <= IDLE;
            md_cnt       <= '0;
            md_timeout_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
            if (md_timeout_set) begin
                md_timeout_q <= 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt      = state;
        md_cnt_nxt     = md_cnt;
        md_timeout_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (md_go) begin
                    state_nxt  = MD_RUN;
                    md_cnt_nxt = CNT_W'(1);
                end
            end
            MD_RUN: begin
                if (kill || md_done_i || md_at_limit) begin
                    state_nxt      = IDLE;
                    md_cnt_nxt     = '0;
                    md_timeout_set = md_tmo;
                end else begin
                    md_cnt_nxt = md_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt  = IDLE;
                md_cnt_nxt = '0;
            end
        endcase
    end

    // Output priority mux: kill > branch > mul/div > load-use.
    always_comb begin
        stall_IF    = 1'b0;
        stall_ID    = 1'b0;
        stall_EX    = 1'b0;
        bubble_EX   = 1'b0;
        bubble_MEM  = 1'b0;
        flush_IFID  = 1'b0;
        flush_IDEX  = 1'b0;
        flush_EXMEM = 1'b0;
        md_start_o  = 1'b0;
        md_abort_o  = 1'b0;
        if (!reset_i) begin
            if (kill) begin
                flush_IFID  = 1'b1;
                flush_IDEX  = 1'b1;
                flush_EXMEM = 1'b1;
                md_abort_o  = (state == MD_RUN);
            end else begin
                // While MD_RUN the EX slot holds the mul/div, so a branch
                // indication there cannot be genuine and is not acted on.
                if (branch_taken_EX && (state == IDLE)) begin
                    flush_IFID = 1'b1;
                    flush_IDEX = 1'b1;
                end else if (md_go || md_hold) begin
                    // ID/EX is held, never bubbled, so a pending load-use waits.
                    stall_IF   = 1'b1;
                    stall_ID   = 1'b1;
                    stall_EX   = 1'b1;
                    bubble_MEM = 1'b1;
                    md_start_o = md_go;
                end else if (lu) begin
                    stall_IF  = 1'b1;
                    stall_ID  = 1'b1;
                    bubble_EX = 1'b1;
                end
                md_abort_o = md_tmo;
            end
        end
    end

    assign md_busy_o    = (state == MD_RUN) && !reset_i;
    assign md_timeout_o = md_timeout_q && !reset_i;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam logic [11:0] S_IF    = 12'h800;
    localparam logic [11:0] S_ID    = 12'h400;
    localparam logic [11:0] S_EX    = 12'h200;
    localparam logic [11:0] B_EX    = 12'h100;
    localparam logic [11:0] B_MEM   = 12'h080;
    localparam logic [11:0] F_IFID  = 12'h040;
    localparam logic [11:0] F_IDEX  = 12'h020;
    localparam logic [11:0] F_EXMEM = 12'h010;
    localparam logic [11:0] START   = 12'h008;
    localparam logic [11:0] ABORT   = 12'h004;
    localparam logic [11:0] BUSY    = 12'h002;
    localparam logic [11:0] TMO     = 12'h001;

    localparam logic [11:0] NONE    = 12'h000;
    localparam logic [11:0] LU_STL  = S_IF | S_ID | B_EX;
    localparam logic [11:0] MD_STL  = S_IF | S_ID | S_EX | B_MEM;
    localparam logic [11:0] F_ALL   = F_IFID | F_IDEX | F_EXMEM;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [4:0] rs1_ID, rs2_ID, idex_rd;
    logic       use_rs1_ID, use_rs2_ID, idex_wb, idex_memread;
    logic       ex_muldiv, md_done_i, branch_taken_EX, trap_i;
    logic       stall_IF, stall_ID, stall_EX, bubble_EX, bubble_MEM;
    logic       flush_IFID, flush_IDEX, flush_EXMEM;
    logic       md_start_o, md_abort_o, md_busy_o, md_timeout_o;

    logic [11:0] obs;

    typedef struct {
        string       tag;
        logic [11:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  checks   = 0;
    int  failures = 0;

    always #5 clk_i = ~clk_i;

    pipeline_hazard_ctrl #(.MD_TIMEOUT(8)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .rs1_ID          (rs1_ID),
        .rs2_ID          (rs2_ID),
        .use_rs1_ID      (use_rs1_ID),
        .use_rs2_ID      (use_rs2_ID),
        .idex_rd         (idex_rd),
        .idex_wb         (idex_wb),
        .idex_memread    (idex_memread),
        .ex_muldiv       (ex_muldiv),
        .md_done_i       (md_done_i),
        .branch_taken_EX (branch_taken_EX),
        .trap_i          (trap_i),
        .stall_IF        (stall_IF),
        .stall_ID        (stall_ID),
        .stall_EX        (stall_EX),
        .bubble_EX       (bubble_EX),
        .bubble_MEM      (bubble_MEM),
        .flush_IFID      (flush_IFID),
        .flush_IDEX      (flush_IDEX),
        .flush_EXMEM     (flush_EXMEM),
        .md_start_o      (md_start_o),
        .md_abort_o      (md_abort_o),
        .md_busy_o       (md_busy_o),
        .md_timeout_o    (md_timeout_o)
    );

    assign obs = {stall_IF, stall_ID, stall_EX, bubble_EX, bubble_MEM,
                  flush_IFID, flush_IDEX, flush_EXMEM,
                  md_start_o, md_abort_o, md_busy_o, md_timeout_o};

    // Queue the expectation for the current inputs, compare mid-cycle,
    // then advance to just after the next rising edge.
    task automatic step(input string tag, input logic [11:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
        @(negedge clk_i);
        e = sb_q.pop_front();
        checks++;
        assert (obs === e.exp) else begin
            failures++;
            $error("FAIL %s observed=%03h expected=%03h", e.tag, obs, e.exp);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        rs1_ID = 5'd0; rs2_ID = 5'd0; use_rs1_ID = 1'b0; use_rs2_ID = 1'b0;
        idex_rd = 5'd0; idex_wb = 1'b1; idex_memread = 1'b0;
        ex_muldiv = 1'b0; md_done_i = 1'b0; branch_taken_EX = 1'b0; trap_i = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        idex_memread = 1'b1; idex_wb = 1'b0; idex_rd = rd;
        use_rs2_ID = 1'b1; rs2_ID = rd;
    endtask

    initial begin
        idle_inputs();
        reset_i   = 1'b1;
        ex_muldiv = 1'b1;

        // Reset held with a mul/div request present.
        step("reset_c0", NONE);
        step("reset_c1", NONE);
        step("reset_c2", NONE);
        reset_i = 1'b0;
        idle_inputs();
        step("post_reset_idle", NONE);

        // Load-use on rs2 = x5: one-cycle stall, then clear.
        set_lu(5'd5);
        step("lu_rs2_x5", LU_STL);
        idle_inputs();
        step("lu_released", NONE);
        set_lu(5'd0);
        step("lu_x0_no_stall", NONE);
        set_lu(5'd7);
        idex_wb = 1'b1;
        step("lu_no_writeback", NONE);
        idle_inputs();
        idex_memread = 1'b1; idex_wb = 1'b0; idex_rd = 5'd9;
        rs1_ID = 5'd9; use_rs1_ID = 1'b0;
        step("lu_rs1_unused", NONE);
        use_rs1_ID = 1'b1;
        step("lu_rs1_used", LU_STL);
        idle_inputs();

        // Mul/div with done at cycle 4; load-use held off while frozen.
        ex_muldiv = 1'b1;
        step("md_c0_start", MD_STL | START);
        step("md_c1", MD_STL | BUSY);
        set_lu(5'd3);
        step("md_c2_lu_held", MD_STL | BUSY);
        idex_memread = 1'b0; idex_wb = 1'b1; use_rs2_ID = 1'b0;
        step("md_c3", MD_STL | BUSY);
        md_done_i = 1'b1;
        step("md_c4_done", BUSY);

        // Back-to-back restart, then trap at cycle 2 of MD_RUN.
        md_done_i = 1'b0;
        step("md2_c0_start", MD_STL | START);
        step("md2_c1", MD_STL | BUSY);
        trap_i = 1'b1;
        step("md2_c2_trap", F_ALL | ABORT | BUSY);
        idle_inputs();
        step("post_trap_idle", NONE);
        md_done_i = 1'b1;
        step("done_in_idle", NONE);
        md_done_i = 1'b0;

        // Timeout: released on the 9th cycle with an abort pulse.
        ex_muldiv = 1'b1;
        step("tmo_c0_start", MD_STL | START);
        for (int i = 1; i < 8; i++) begin
            step($sformatf("tmo_c%0d", i), MD_STL | BUSY);
        end
        step("tmo_c8_release", ABORT | BUSY);
        ex_muldiv = 1'b0;
        step("tmo_sticky_a", TMO);
        step("tmo_sticky_b", TMO);

        // Branch dominates load-use and mul/div start; trap in IDLE.
        branch_taken_EX = 1'b1;
        set_lu(5'd4);
        step("branch_lu", F_IFID | F_IDEX | TMO);
        idle_inputs();
        branch_taken_EX = 1'b1;
        ex_muldiv = 1'b1;
        step("branch_md", F_IFID | F_IDEX | TMO);
        idle_inputs();
        trap_i = 1'b1;
        step("trap_idle", F_ALL | TMO);
        idle_inputs();

        // Reset mid-run: no abort pulse, flag and state cleared.
        ex_muldiv = 1'b1;
        step("rst_run_start", MD_STL | START | TMO);
        step("rst_run_c1", MD_STL | BUSY | TMO);
        reset_i = 1'b1;
        ex_muldiv = 1'b0;
        step("rst_mid_run", NONE);
        reset_i = 1'b0;
        step("rst_after", NONE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
